// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle datapath (IF/ID/EX/MEM/WB).
// Ports: clk_i/rst_i clock and sync active-high reset; opcode_i sampled in ID;
// cond_i branch condition sampled in EX; mem_rdy_i memory ack; estado_o state code;
// mem_req_o/mem_we_o/addr_sel_o memory handshake; ir_we_o/pc_we_o/pc_sel_o/reg_we_o/wb_sel_o
// datapath strobes; halted_o/fault_o terminal flags; instr_cnt_o retired-instruction count.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic             cond_i,
  input  logic             mem_rdy_i,
  output logic [2:0]       estado_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_sel_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic             reg_we_o,
  output logic             wb_sel_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] instr_cnt_o
);
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_HALT = 3'd5, S_FAULT = 3'd6, S_RST = 3'd7
  } state_e;
  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BR, C_JMP} cls_e;
  state_e state_q, state_d;
  cls_e cls_q, cls_d;
  logic first_q;
  logic [7:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic timeout, retire;
  assign timeout = wcnt_q == 8'(MEM_TIMEOUT);
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    addr_sel_o = 1'b0;
    ir_we_o = 1'b0;
    pc_we_o = 1'b0;
    pc_sel_o = 1'b0;
    reg_we_o = 1'b0;
    wb_sel_o = 1'b0;
    halted_o = 1'b0;
    fault_o = 1'b0;
    case (state_q)
      // first_q holds RSTS for one extra cycle after reset is released
      S_RST: state_d = first_q ? S_RST : S_IF;
      S_IF: begin
        mem_req_o = 1'b1;
        ir_we_o = mem_rdy_i;
        pc_we_o = mem_rdy_i;
        state_d = mem_rdy_i ? S_ID : timeout ? S_FAULT : S_IF;
      end
      S_ID: begin
        state_d = S_EX;
        case (opcode_i)
          6'h00, 6'h01: cls_d = C_ALU;
          6'h10: cls_d = C_LOAD;
          6'h11: cls_d = C_STORE;
          6'h20: cls_d = C_BR;
          6'h21: cls_d = C_JMP;
          6'h3F: state_d = S_HALT;
          default: state_d = S_FAULT;
        endcase
      end
      S_EX: begin
        pc_sel_o = cls_q == C_BR || cls_q == C_JMP;
        pc_we_o = cls_q == C_BR ? cond_i : cls_q == C_JMP;
        state_d = cls_q == C_ALU ? S_WB : (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_IF;
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o = cls_q == C_STORE;
        state_d = mem_rdy_i ? (cls_q == C_STORE ? S_IF : S_WB) : timeout ? S_FAULT : S_MEM;
      end
      S_WB: begin
        reg_we_o = 1'b1;
        wb_sel_o = cls_q == C_LOAD;
        state_d = S_IF;
      end
      S_HALT: halted_o = 1'b1;
      S_FAULT: fault_o = 1'b1;
    endcase
  end
  // wait counter restarts on every state change; only IF/MEM waits advance it
  assign wcnt_d = state_d != state_q ? 8'd0 : (mem_req_o && !mem_rdy_i) ? wcnt_q + 8'd1 : wcnt_q;
  assign retire = state_d == S_IF && (state_q == S_EX || state_q == S_MEM || state_q == S_WB);
  assign cnt_d = cnt_q + CNT_W'(retire);
  always_ff @(posedge clk_i) begin
    first_q <= rst_i;
    if (rst_i) begin
      state_q <= S_RST;
      cls_q <= C_ALU;
      wcnt_q <= 8'd0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      wcnt_q <= wcnt_d;
      cnt_q <= cnt_d;
    end
  end
  assign estado_o = state_q;
  assign instr_cnt_o = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst, cond, mem_rdy;
  logic [5:0] opcode;
  logic [2:0] estado;
  logic mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel, halted, fault;
  logic [3:0] instr_cnt;
  int errors = 0, checks = 0;
  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .cond_i(cond), .mem_rdy_i(mem_rdy),
    .estado_o(estado), .mem_req_o(mem_req), .mem_we_o(mem_we), .addr_sel_o(addr_sel),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_sel_o(pc_sel), .reg_we_o(reg_we), .wb_sel_o(wb_sel),
    .halted_o(halted), .fault_o(fault), .instr_cnt_o(instr_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nx;
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    mem_rdy = 1'b0;
    nx();
    rst = 1'b0;
    nx();
    nx();
  endtask
  task automatic fetch(input logic [5:0] op);
    mem_rdy = 1'b1;
    #1;
    chk("if_state", 32'(estado), 32'd0);
    chk("if_ir_pc_we", {ir_we, pc_we, pc_sel, mem_req, addr_sel}, 32'b11010);
    nx();
    mem_rdy = 1'b0;
    opcode = op;
    #1;
    chk("id_state", 32'(estado), 32'd1);
    nx();
  endtask
  initial begin
    rst = 1'b1;
    opcode = 6'h00;
    cond = 1'b0;
    mem_rdy = 1'b1;
    nx();
    nx();
    chk("rst_state", 32'(estado), 32'd7);
    chk("rst_outs", {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel, halted, fault}, 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    rst = 1'b0;
    nx();
    chk("rsts_hold", 32'(estado), 32'd7);
    chk("rsts_hold_req", 32'(mem_req), 32'd0);
    nx();
    fetch(6'h00);
    chk("alu_ex", 32'(estado), 32'd2);
    chk("alu_ex_pcwe", 32'(pc_we), 32'd0);
    nx();
    chk("alu_wb", {29'(estado), reg_we, wb_sel, mem_req}, {29'd4, 3'b100});
    nx();
    chk("alu_ret", {28'(estado), instr_cnt}, {28'd0, 4'd1});
    fetch(6'h10);
    nx();
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_wait", {29'(estado), mem_req, addr_sel, mem_we}, {29'd3, 3'b110});
      nx();
    end
    mem_rdy = 1'b1;
    #1;
    chk("ld_mem_rdy", {29'(estado), mem_req, addr_sel, mem_we}, {29'd3, 3'b110});
    nx();
    mem_rdy = 1'b0;
    chk("ld_wb", {29'(estado), reg_we, wb_sel, mem_req}, {29'd4, 3'b110});
    nx();
    chk("ld_ret", {28'(estado), instr_cnt}, {28'd0, 4'd2});
    fetch(6'h11);
    nx();
    mem_rdy = 1'b1;
    #1;
    chk("st_mem", {29'(estado), mem_req, addr_sel, mem_we}, {29'd3, 3'b111});
    chk("st_no_regwe", {ir_we, reg_we}, 32'd0);
    nx();
    mem_rdy = 1'b0;
    chk("st_ret", {28'(estado), instr_cnt}, {28'd0, 4'd3});
    cond = 1'b0;
    fetch(6'h20);
    chk("br_nt", {29'(estado), pc_we, pc_sel}, {29'd2, 2'b01});
    nx();
    chk("br_nt_ret", {28'(estado), instr_cnt}, {28'd0, 4'd4});
    cond = 1'b1;
    fetch(6'h20);
    chk("br_t", {29'(estado), pc_we, pc_sel}, {29'd2, 2'b11});
    nx();
    cond = 1'b0;
    chk("br_t_ret", {28'(estado), instr_cnt}, {28'd0, 4'd5});
    fetch(6'h21);
    chk("jmp", {29'(estado), pc_we, pc_sel}, {29'd2, 2'b11});
    nx();
    chk("jmp_ret", {28'(estado), instr_cnt}, {28'd0, 4'd6});
    mem_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_if_wait", {31'(estado), mem_req}, {31'd0, 1'b1});
      nx();
    end
    chk("to_fault", {29'(estado), fault, halted, mem_req}, {29'd6, 3'b100});
    mem_rdy = 1'b1;
    nx();
    nx();
    chk("fault_sticky", {29'(estado), fault, ir_we, pc_we}, {29'd6, 3'b100});
    do_reset();
    chk("rst_cnt_clear", {28'(estado), instr_cnt}, {28'd0, 4'd0});
    for (int i = 0; i < 15; i++) nx();
    mem_rdy = 1'b1;
    #1;
    chk("to_last_rdy", {ir_we, pc_we}, 32'b11);
    nx();
    mem_rdy = 1'b0;
    opcode = 6'h3F;
    chk("to_last_id", 32'(estado), 32'd1);
    nx();
    chk("halt", {29'(estado), halted, fault, mem_req}, {29'd5, 3'b100});
    nx();
    chk("halt_cnt", {28'(estado), instr_cnt}, {28'd5, 4'd0});
    do_reset();
    fetch(6'h2A);
    chk("illegal", {29'(estado), fault, halted, pc_we}, {29'd6, 3'b100});
    do_reset();
    for (int i = 0; i < 17; i++) begin
      fetch(6'h01);
      nx();
      nx();
    end
    chk("cnt_wrap", {28'(estado), instr_cnt}, {28'd0, 4'd1});
    fetch(6'h10);
    nx();
    nx();
    nx();
    chk("mem_wait_pre_rst", {31'(estado), mem_req}, {31'd3, 1'b1});
    rst = 1'b1;
    nx();
    chk("mid_mem_rst", {28'(estado), instr_cnt}, {28'd7, 4'd0});
    chk("mid_mem_rst_req", {mem_req, addr_sel}, 32'd0);
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
